// File: rtl/m_pkg.sv
// Shared types for the m ingress path: beat format, arbiter port index and
// arbiter FSM state.
package m_pkg;

    localparam int LEN_W  = 8;
    localparam int DATA_W = 32;

    typedef logic [2:0] arb_port_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [LEN_W-1:0]  length;
        logic [DATA_W-1:0] data;
    } in_t;

    // Round-robin successor of port p among n ports.
    function automatic arb_port_t next_port(arb_port_t p, int n);
        return (int'(p) == n - 1) ? arb_port_t'(0) : arb_port_t'(p + 3'd1);
    endfunction

endpackage

// File: rtl/m_arb_rr.sv
// Combinational round-robin picker: first requesting port at or after ptr,
// wrapping N-1 -> 0.
module m_arb_rr
    import m_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  arb_port_t    ptr,
    output logic [N-1:0] gnt,
    output arb_port_t    idx,
    output logic         any
);

    int p;

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        p   = 0;
        for (int k = 0; k < N; k++) begin
            p = int'(ptr) + k;
            if (p >= N) p = p - N;
            if (!any && req[p]) begin
                any = 1'b1;
                idx = arb_port_t'(p);
            end
        end
        for (int i = 0; i < N; i++) begin
            gnt[i] = any && (int'(idx) == i);
        end
    end

endmodule

// File: rtl/m_ingress_arb.sv
// Packet-granular round-robin arbiter merging N ingress beat streams into one
// registered stream with no downstream backpressure.
module m_ingress_arb
    import m_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_vld_w,
    input  in_t          req_w [N],
    output logic [N-1:0] req_rdy_w,
    output logic         out_vld_r,
    output in_t          out_r,
    output arb_port_t    out_port_r,
    output logic         err_r
);

    arb_state_t   state_r, state_nxt;
    arb_port_t    ptr_r, ptr_nxt;
    arb_port_t    owner_r, owner_nxt;
    logic [N-1:0] sop_vec, nsop_vec, arb_req, gnt;
    arb_port_t    gnt_idx, sel;
    logic         gnt_any, sel_vld, fwd, err;
    logic [N-1:0] rdy_c;
    in_t          sel_beat;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            sop_vec[i]  = req_vld_w[i] & req_w[i].sop;
            nsop_vec[i] = req_vld_w[i] & ~req_w[i].sop;
        end
    end

    // Start-of-packet candidates always win; stray non-sop beats only get
    // picked (for discard) when nobody is trying to start a packet.
    assign arb_req = (|sop_vec) ? sop_vec : nsop_vec;

    m_arb_rr #(.N(N)) u_rr (
        .req (arb_req),
        .ptr (ptr_r),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    always_comb begin
        state_nxt = state_r;
        ptr_nxt   = ptr_r;
        owner_nxt = owner_r;
        rdy_c     = '0;
        sel       = owner_r;
        fwd       = 1'b0;
        err       = 1'b0;
        sel_beat  = '0;

        if (state_r == ARB_IDLE) begin
            if (gnt_any) begin
                rdy_c = gnt;
                sel   = gnt_idx;
            end
        end else begin
            for (int i = 0; i < N; i++) rdy_c[i] = (int'(owner_r) == i);
        end

        for (int i = 0; i < N; i++) begin
            if (rdy_c[i]) sel_beat = req_w[i];
        end
        sel_vld = |(req_vld_w & rdy_c);

        if (sel_vld) begin
            if (state_r == ARB_IDLE) begin
                if (sel_beat.sop) begin
                    fwd = 1'b1;
                    if (sel_beat.eop) begin
                        ptr_nxt = next_port(sel, N);
                    end else begin
                        state_nxt = ARB_BUSY;
                        owner_nxt = sel;
                    end
                end else begin
                    err = 1'b1;
                end
            end else begin
                // A repeated sop from the owner restarts its packet in place.
                fwd = 1'b1;
                err = sel_beat.sop;
                if (sel_beat.eop) begin
                    state_nxt = ARB_IDLE;
                    ptr_nxt   = next_port(owner_r, N);
                end
            end
        end
    end

    assign req_rdy_w = rst ? '0 : rdy_c;

    // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ARB_IDLE;
            ptr_r   <= '0;
            owner_r <= '0;
        end else begin
            state_r <= state_nxt;
            ptr_r   <= ptr_nxt;
            owner_r <= owner_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_r  <= 1'b0;
            out_r      <= '0;
            out_port_r <= '0;
            err_r      <= 1'b0;
        end else begin
            out_vld_r <= fwd;
            err_r     <= err;
            if (fwd) begin
                out_r      <= sel_beat;
                out_port_r <= sel;
            end
        end
    end

endmodule

// File: tb/tb_m_ingress_arb.sv
// Self-checking bench for m_ingress_arb: directed packet scenarios plus
// randomized traffic compared cycle by cycle against a packet-level model.
module tb_m_ingress_arb;
    import m_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_vld_w;
    in_t          req_w [N];
    logic [N-1:0] req_rdy_w;
    logic         out_vld_r;
    in_t          out_r;
    arb_port_t    out_port_r;
    logic         err_r;

    always #5 clk = ~clk;

    m_ingress_arb #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_vld_w  (req_vld_w),
        .req_w      (req_w),
        .req_rdy_w  (req_rdy_w),
        .out_vld_r  (out_vld_r),
        .out_r      (out_r),
        .out_port_r (out_port_r),
        .err_r      (err_r)
    );

    typedef struct {
        bit  idle;
        in_t beat;
    } slot_t;

    typedef struct {
        bit  vld;
        int  port;
        bit  err;
        in_t beat;
    } obs_t;

    slot_t src_q [N][$];
    obs_t  log_q [$];

    int checks = 0;
    int errors = 0;

    // Model: packet owner (if any), round-robin pointer, and the output
    // registers expected after the next clock edge.
    bit  m_busy;
    int  m_owner, m_ptr;
    bit  e_vld, e_err;
    in_t e_out;
    int  e_port;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_ptr   = 0;
        e_vld   = 0;
        e_err   = 0;
        e_out   = '0;
        e_port  = 0;
    endtask

    function automatic int pick(logic [N-1:0] m, int start);
        for (int k = 0; k < N; k++) begin
            if (m[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic step(bit rst_val);
        logic [N-1:0] vld, sopm, nsopm, rdy_exp, was_idle;
        logic [63:0]  r;
        int           w;
        in_t          b;
        obs_t         o;

        @(negedge clk);
        check("out_vld_r", out_vld_r, e_vld);
        check("err_r", err_r, e_err);
        check("out_r", out_r, e_out);
        check("out_port_r", out_port_r, e_port);
        o.vld = out_vld_r; o.port = int'(out_port_r); o.err = err_r; o.beat = out_r;
        log_q.push_back(o);

        rst = rst_val;
        for (int i = 0; i < N; i++) begin
            was_idle[i] = (src_q[i].size() > 0) && src_q[i][0].idle;
            if (src_q[i].size() > 0 && !src_q[i][0].idle) begin
                vld[i]   = 1'b1;
                req_w[i] = src_q[i][0].beat;
            end else begin
                vld[i]   = 1'b0;
                r        = {$urandom, $urandom};
                req_w[i] = r[$bits(in_t)-1:0];
            end
            sopm[i]  = vld[i] & req_w[i].sop;
            nsopm[i] = vld[i] & ~req_w[i].sop;
        end
        req_vld_w = vld;

        rdy_exp = '0;
        w       = -1;
        if (!rst_val) begin
            if (m_busy) w = m_owner;
            else begin
                w = pick(sopm, m_ptr);
                if (w < 0) w = pick(nsopm, m_ptr);
            end
            if (w >= 0) rdy_exp[w] = 1'b1;
        end

        #1;
        check("req_rdy_w", req_rdy_w, rdy_exp);

        if (rst_val) begin
            model_reset();
        end else begin
            e_vld = 0;
            e_err = 0;
            if (w >= 0 && vld[w]) begin
                b = req_w[w];
                void'(src_q[w].pop_front());
                if (m_busy) begin
                    e_vld = 1; e_out = b; e_port = w; e_err = b.sop;
                    if (b.eop) begin
                        m_busy = 0;
                        m_ptr  = (w + 1) % N;
                    end
                end else if (b.sop) begin
                    e_vld = 1; e_out = b; e_port = w;
                    if (b.eop) m_ptr = (w + 1) % N;
                    else begin
                        m_busy  = 1;
                        m_owner = w;
                    end
                end else begin
                    e_err = 1;
                end
            end
        end

        for (int i = 0; i < N; i++) begin
            if (was_idle[i]) void'(src_q[i].pop_front());
        end
    endtask

    task automatic add_beat(int p, bit sop, bit eop, int len);
        slot_t s;
        s.idle             = 0;
        s.beat.sop         = sop;
        s.beat.eop         = eop;
        s.beat.length      = LEN_W'(len);
        s.beat.data        = $urandom;
        src_q[p].push_back(s);
    endtask

    task automatic add_idle(int p, int n);
        slot_t s;
        s.idle = 1;
        s.beat = '0;
        for (int k = 0; k < n; k++) src_q[p].push_back(s);
    endtask

    task automatic add_pkt(int p, int n);
        for (int k = 0; k < n; k++) add_beat(p, k == 0, k == n - 1, n);
    endtask

    // Random packet with occasional gaps and protocol violations.
    task automatic add_rand_pkt(int p);
        int  n;
        bit  sop;
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) add_idle(p, $urandom_range(1, 2));
            sop = (k == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 11) == 0);
            add_beat(p, sop, k == n - 1, n);
        end
    endtask

    task automatic restart();
        for (int i = 0; i < N; i++) src_q[i].delete();
        step(1);
        log_q.delete();
    endtask

    initial begin
        int p1_eop, p3_first, errs, vlds;
        int exp032 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

        rst       = 1'b1;
        req_vld_w = '0;
        for (int i = 0; i < N; i++) req_w[i] = '0;
        model_reset();
        step(1);
        step(1);

        // Ports 0 and 2 each send a 3-beat packet from cycle 1.
        restart();
        add_pkt(0, 3);
        add_pkt(2, 3);
        for (int c = 0; c < 8; c++) step(0);
        for (int c = 1; c <= 3; c++) begin
            check("t031_p0_vld", log_q[c].vld, 1);
            check("t031_p0_port", log_q[c].port, 0);
        end
        for (int c = 4; c <= 6; c++) begin
            check("t031_p2_vld", log_q[c].vld, 1);
            check("t031_p2_port", log_q[c].port, 2);
        end
        check("t031_p0_sop", log_q[1].beat.sop, 1);
        check("t031_p2_eop", log_q[6].beat.eop, 1);
        check("t031_idle_after", log_q[7].vld, 0);
        check("t031_model_ptr", m_ptr, 3);
        log_q.delete();
        add_pkt(0, 1);
        add_pkt(3, 1);
        for (int c = 0; c < 3; c++) step(0);
        check("t031_ptr_first", log_q[1].port, 3);
        check("t031_ptr_second", log_q[2].port, 0);

        // All four ports offer single-beat packets continuously.
        restart();
        for (int i = 0; i < N; i++) for (int k = 0; k < 8; k++) add_pkt(i, 1);
        for (int c = 0; c < 9; c++) step(0);
        for (int c = 1; c <= 8; c++) begin
            check("t032_vld", log_q[c].vld, 1);
            check("t032_port", log_q[c].port, exp032[c-1]);
        end

        // Port 1 packet with a two-cycle gap; port 3 waits for its eop.
        restart();
        add_beat(1, 1, 0, 4);
        add_beat(1, 0, 0, 4);
        add_idle(1, 2);
        add_beat(1, 0, 0, 4);
        add_beat(1, 0, 1, 4);
        add_pkt(3, 1);
        for (int c = 0; c < 10; c++) step(0);
        p1_eop   = -1;
        p3_first = -1;
        for (int c = 0; c < log_q.size(); c++) begin
            if (log_q[c].vld && log_q[c].port == 1 && log_q[c].beat.eop && p1_eop < 0) p1_eop = c;
            if (log_q[c].vld && log_q[c].port == 3 && p3_first < 0) p3_first = c;
        end
        check("t033_gap1", log_q[3].vld, 0);
        check("t033_gap2", log_q[4].vld, 0);
        check("t033_p1_eop_at", p1_eop, 6);
        check("t033_p3_at", p3_first, 7);

        // Stray non-sop beat in IDLE is dropped with an error pulse.
        restart();
        add_beat(2, 0, 1, 1);
        for (int c = 0; c < 3; c++) step(0);
        check("t034_vld", log_q[1].vld, 0);
        check("t034_err", log_q[1].err, 1);
        check("t034_err_end", log_q[2].err, 0);

        // Reset mid-packet: trailing beats are discarded.
        restart();
        add_pkt(0, 4);
        step(0);
        step(0);
        step(1);
        for (int c = 0; c < 4; c++) step(0);
        check("t035_b1", log_q[1].vld, 1);
        check("t035_b2", log_q[2].vld, 1);
        errs = 0;
        vlds = 0;
        for (int c = 3; c <= 6; c++) begin
            errs += int'(log_q[c].err);
            vlds += int'(log_q[c].vld);
        end
        check("t035_err_pulses", errs, 2);
        check("t035_no_vld", vlds, 0);

        // Randomized traffic against the model.
        restart();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(0, 2) != 0) add_rand_pkt(i);
            end
            step($urandom_range(0, 299) == 0);
            if (log_q.size() > 16) log_q.delete();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
